// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter slice: RAM handshake state and arbiter FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: prefers core rr when it requests, otherwise the other core.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       grant,
  output logic       valid
);

  // Pick the favoured core if pending, else fall back to the other one.
  always_comb begin
    valid = |req;
    grant = rr;
    if (!req[rr]) grant = ~rr;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for two cores (dcache/icache each). Dcache beats icache,
// round-robin between cores, icache forced after STARVE_MAX dcache blocks while it waits.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_t state, state_n;
  logic       owner, owner_n;
  logic       rr, rr_n;
  logic [2:0] starve_cnt, starve_cnt_n;

  logic [1:0] d_req;
  logic       d_core, d_any;
  logic       i_core, i_any;
  logic       force_i;

  assign d_req   = dREN | dWEN;
  assign force_i = (starve_cnt == STARVE_LIM) && i_any;

  rr_pick2 u_pick_d (
    .req   (d_req),
    .rr    (rr),
    .grant (d_core),
    .valid (d_any)
  );

  rr_pick2 u_pick_i (
    .req   (iREN),
    .rr    (rr),
    .grant (i_core),
    .valid (i_any)
  );

  // State, owner, round-robin pointer and starvation counter registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr         <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      rr         <= rr_n;
      starve_cnt <= starve_cnt_n;
    end
  end

  // Next-state selection and RAM/cache side outputs from state plus owner's inputs.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    rr_n         = rr;
    starve_cnt_n = starve_cnt;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = '1;
    dwait        = '1;
    iload        = {ramload, ramload};
    dload        = {ramload, ramload};

    case (state)
      IDLE: begin
        if (!i_any) starve_cnt_n = '0;
        if (force_i) begin
          state_n      = GRANT_I;
          owner_n      = i_core;
          rr_n         = ~i_core;
          starve_cnt_n = '0;
        end else if (d_any) begin
          state_n = GRANT_D;
          owner_n = d_core;
          rr_n    = ~d_core;
          if (i_any && (starve_cnt != STARVE_LIM)) starve_cnt_n = starve_cnt + 3'd1;
        end else if (i_any) begin
          state_n      = GRANT_I;
          owner_n      = i_core;
          rr_n         = ~i_core;
          starve_cnt_n = '0;
        end
      end

      GRANT_D: begin
        ramaddr      = daddr[owner];
        ramstore     = dstore[owner];
        dwait[owner] = (ramstate != ACCESS);
        if (dWEN[owner])      ramWEN = 1'b1;
        else if (dREN[owner]) ramREN = 1'b1;
        // Word 0 of a block keeps the grant; word 1 or an abandoned request releases it.
        if (!d_req[owner])
          state_n = IDLE;
        else if ((ramstate == ACCESS) && daddr[owner][2])
          state_n = IDLE;
      end

      GRANT_I: begin
        ramREN       = 1'b1;
        ramaddr      = iaddr[owner];
        iwait[owner] = (ramstate != ACCESS);
        if (!iREN[owner] || (ramstate == ACCESS)) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both caches and the RAM.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN, dWEN;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_expect(input string tag);
    check_eq({tag, ".ren"}, {31'd0, ramREN}, 32'd0);
    check_eq({tag, ".wen"}, {31'd0, ramWEN}, 32'd0);
    check_eq({tag, ".dwait"}, {30'd0, dwait}, 32'd3);
    check_eq({tag, ".iwait"}, {30'd0, iwait}, 32'd3);
  endtask

  task automatic do_reset();
    nRST     = 1'b0;
    iREN     = '0;
    dREN     = '0;
    dWEN     = '0;
    ramstate = FREE;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    nRST     = 1'b0;
    iREN     = 2'b11;
    dREN     = 2'b11;
    dWEN     = 2'b00;
    iaddr[0] = 32'h300; iaddr[1] = 32'h500;
    daddr[0] = 32'h100; daddr[1] = 32'h200;
    dstore[0] = 32'h1111; dstore[1] = 32'h2222;
    ramload  = 32'hCAFE0001;
    ramstate = ACCESS;

    // Reset with every request asserted
    tick();
    tick();
    idle_expect("rst");
    check_eq("rst.addr", ramaddr, 32'h0);
    check_eq("rst.store", ramstore, 32'h0);
    iREN = '0;
    nRST = 1'b1;
    tick();
    check_eq("rst.first_addr", ramaddr, 32'h100);
    check_eq("rst.first_dwait", {30'd0, dwait}, 32'd2);

    // Two dcache block reads back to back
    do_reset();
    dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200; ramstate = ACCESS;
    settle();
    idle_expect("blk.idle0");
    tick();
    check_eq("blk.d0w0.addr", ramaddr, 32'h100);
    check_eq("blk.d0w0.ren", {31'd0, ramREN}, 32'd1);
    check_eq("blk.d0w0.dwait", {30'd0, dwait}, 32'd2);
    check_eq("blk.d0w0.dload", dload[0], 32'hCAFE0001);
    tick();
    daddr[0] = 32'h104;
    settle();
    check_eq("blk.d0w1.addr", ramaddr, 32'h104);
    check_eq("blk.d0w1.dwait", {30'd0, dwait}, 32'd2);
    tick();
    dREN = 2'b10;
    settle();
    idle_expect("blk.idle1");
    tick();
    check_eq("blk.d1w0.addr", ramaddr, 32'h200);
    check_eq("blk.d1w0.dwait", {30'd0, dwait}, 32'd1);
    tick();
    daddr[1] = 32'h204;
    settle();
    check_eq("blk.d1w1.addr", ramaddr, 32'h204);
    tick();
    dREN = 2'b00;
    settle();
    idle_expect("blk.idle2");
    dREN = 2'b11; daddr[0] = 32'h10C; daddr[1] = 32'h20C;
    tick();
    check_eq("blk.rr_probe", ramaddr, 32'h10C);
    tick();
    dREN = '0;

    // icache0 and dcache1 write: dcache block first
    do_reset();
    iREN = 2'b01; iaddr[0] = 32'h300;
    dWEN = 2'b10; daddr[1] = 32'h400; dstore[1] = 32'hDEAD; ramstate = ACCESS;
    ramload = 32'h0BADF00D;
    settle();
    idle_expect("mix.idle0");
    tick();
    check_eq("mix.w0.wen", {31'd0, ramWEN}, 32'd1);
    check_eq("mix.w0.ren", {31'd0, ramREN}, 32'd0);
    check_eq("mix.w0.addr", ramaddr, 32'h400);
    check_eq("mix.w0.store", ramstore, 32'hDEAD);
    check_eq("mix.w0.iwait", {30'd0, iwait}, 32'd3);
    tick();
    daddr[1] = 32'h404; dstore[1] = 32'hBEEF;
    settle();
    check_eq("mix.w1.addr", ramaddr, 32'h404);
    check_eq("mix.w1.store", ramstore, 32'hBEEF);
    check_eq("mix.w1.iwait", {30'd0, iwait}, 32'd3);
    tick();
    dWEN = '0;
    settle();
    idle_expect("mix.idle1");
    tick();
    check_eq("mix.i0.ren", {31'd0, ramREN}, 32'd1);
    check_eq("mix.i0.addr", ramaddr, 32'h300);
    check_eq("mix.i0.iwait", {30'd0, iwait}, 32'd2);
    check_eq("mix.i0.iload", iload[0], 32'h0BADF00D);
    tick();
    iREN = '0;
    settle();
    idle_expect("mix.idle2");

    // icache1 starvation override after four dcache blocks
    do_reset();
    iREN = 2'b10; iaddr[1] = 32'h500;
    dREN = 2'b11; daddr[0] = 32'h104; daddr[1] = 32'h204; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("stv.d%0d.addr", k), ramaddr, (k % 2 == 0) ? 32'h104 : 32'h204);
      check_eq($sformatf("stv.d%0d.iwait", k), {30'd0, iwait}, 32'd3);
      tick();
      check_eq($sformatf("stv.idle%0d", k), {31'd0, ramREN}, 32'd0);
    end
    tick();
    check_eq("stv.i1.addr", ramaddr, 32'h500);
    check_eq("stv.i1.iwait", {30'd0, iwait}, 32'd1);
    check_eq("stv.i1.dwait", {30'd0, dwait}, 32'd3);
    tick();
    check_eq("stv.after.ren", {31'd0, ramREN}, 32'd0);
    tick();
    check_eq("stv.after.addr", ramaddr, 32'h104);
    iREN = '0; dREN = '0;
    tick();

    // BUSY for three cycles, then ACCESS
    do_reset();
    dREN = 2'b01; daddr[0] = 32'h10C; ramstate = BUSY;
    settle();
    idle_expect("busy.idle0");
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) ramstate = ACCESS;
      settle();
      check_eq($sformatf("busy.c%0d.addr", k), ramaddr, 32'h10C);
      check_eq($sformatf("busy.c%0d.dwait", k), {30'd0, dwait}, (k == 3) ? 32'd2 : 32'd3);
    end
    tick();
    dREN = '0;
    settle();
    idle_expect("busy.idle1");

    // Reset asserted during word 1 of a block
    do_reset();
    dREN = 2'b01; daddr[0] = 32'h100; ramstate = ACCESS;
    tick();
    check_eq("mrst.w0.dwait", {30'd0, dwait}, 32'd2);
    tick();
    daddr[0] = 32'h104; ramstate = BUSY; nRST = 1'b0;
    settle();
    check_eq("mrst.w1.addr", ramaddr, 32'h104);
    check_eq("mrst.w1.dwait", {30'd0, dwait}, 32'd3);
    tick();
    ramstate = ACCESS;
    settle();
    idle_expect("mrst.idle");
    nRST = 1'b1;
    tick();
    check_eq("mrst.fresh.addr", ramaddr, 32'h104);
    check_eq("mrst.fresh.dwait", {30'd0, dwait}, 32'd2);
    tick();
    dREN = '0;
    settle();
    idle_expect("mrst.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared RAM port among four cache requesters in the dual-core build: dcache0, dcache1, icache0, icache1. Sits between the per-core caches and the RAM model/controller. Dcache misses, writebacks and flushes are two-word block transfers, and the arbiter holds the grant for a block. Priority is dcache over icache, round-robin between cores, with an anti-starvation override for icache.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive dcache grants allowed while any icache request is pending, before icache is forced.

Ports (index c = core 0/1):
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- iREN[c]  in  1  icache c read request
- iaddr[c]  in  32  icache c word address
- iwait[c]  out  1  icache c wait; 0 for exactly the completing cycle
- iload[c]  out  32  icache c read data (= ramload)
- dREN[c], dWEN[c]  in  1  dcache c read / write request
- daddr[c]  in  32  dcache c word address; bit 2 = block offset
- dstore[c]  in  32  dcache c write data
- dwait[c]  out  1  dcache c wait; 0 for exactly the completing cycle
- dload[c]  out  32  dcache c read data (= ramload)
- ramREN, ramWEN  out  1  RAM request
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR; ACCESS = transfer completes this cycle

## Operation
- States: IDLE, GRANT_D, GRANT_I. Registers: owner core (1b), rr pointer (1b), starve_cnt (3b).
- IDLE: no RAM request, all waits 1. Picks the next owner from pending requests, registered at the edge:
  - If starve_cnt == STARVE_MAX and any iREN is pending, the icache is chosen.
  - Otherwise any dcache request beats any icache request.
  - Within a class, core rr is chosen if it is pending, else the other core.
  - After the grant, rr <= ~granted core.
- GRANT_D: drives ramaddr=daddr[owner] and ramstore=dstore[owner].
  - dWEN[owner] gives ramWEN=1. dREN alone gives ramREN=1. If both are set, WEN wins and REN is not driven.
  - dwait[owner] = !(ramstate==ACCESS).
  - On ACCESS with daddr[owner][2]==0: stay in GRANT_D (block lock).
  - On ACCESS with daddr[2]==1: go to IDLE.
  - If the owner drops both dREN and dWEN: go to IDLE with no RAM request driven that cycle.
- GRANT_I: ramREN=1, ramaddr=iaddr[owner], iwait[owner] = !(ramstate==ACCESS).
  - On ACCESS: go to IDLE.
  - If iREN[owner] drops: go to IDLE.
- ERROR and BUSY are treated as wait. The request is held unchanged, and the owner waits indefinitely.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each dcache block grant made while any iREN is pending.
  - Clears on any icache grant, and whenever no iREN is pending in IDLE.
- Non-owners always see wait=1. iload/dload are ramload, unconditionally.

## Timing
- Reset (synchronous, nRST low at edge) puts the block in IDLE with owner=0, rr=0, starve_cnt=0.
  - Outputs after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, all iwait/dwait=1.
  - Reset mid-grant abandons the transfer. No wait is deasserted.
- Latency: a request seen in IDLE at cycle n gives a RAM request at cycle n+1. With ACCESS in cycle n+1, wait is low in cycle n+1 and the arbiter is back in IDLE at n+2.
- Minimum cost per transaction is one IDLE bubble. A two-word dcache block has no bubble between its words.
- Requests arriving during a grant are considered only in the next IDLE.
- Outputs are combinational from state plus owner inputs. No RAM-side input feeds next-owner selection.

## Structure
- ramstate_t and the arbiter state enum go in cpu_types_pkg. STARVE_MAX stays a module parameter.
- One natural sub-module: rr_pick2 (combinational two-way round-robin picker: req[1:0], rr → grant core, valid). It is instantiated for the dcache class and for the icache class.

## Test plan
- Reset with all requests high → ram*EN=0, all waits 1; release → dcache0 granted first (rr=0).
- dREN0 and dREN1 block reads, ACCESS every cycle → d0 gets 0x100 then 0x104 back-to-back, then IDLE, then d1 gets its two words. rr ends at 0.
- iREN0 and dWEN1 together → dcache1 is served first. icache0 is granted only after dcache1's word with daddr[2]=1 completes.
- iREN1 held while both dcaches request continuously → exactly 4 dcache blocks, then icache1 is granted. starve_cnt returns to 0.
- dcache0 read with ramstate BUSY for 3 cycles then ACCESS → dwait0 low only in the 4th cycle of the grant. The address stays stable throughout.
- nRST asserted mid-GRANT_D after word 0 → next cycle in IDLE, no wait deasserted. The subsequent re-request is treated as fresh arbitration.
